// File: rtl/tmds_pkg.sv
// tmds_pkg: shared TMDS relay constants, output mode encoding and relay state encoding
package tmds_pkg;
    localparam logic [9:0] BLANK_TOKEN = 10'b1101010100;
    localparam logic [9:0] CLK_PATTERN = 10'b0000011111;
    typedef enum logic [1:0] {
        MODE_PASS   = 2'b00,
        MODE_BLANK  = 2'b01,
        MODE_FREEZE = 2'b10,
        MODE_RSVD   = 2'b11
    } mode_e;
    typedef enum logic {
        ST_FILL = 1'b0,
        ST_RUN  = 1'b1
    } state_e;
endpackage

// File: rtl/relay_fifo_mem.sv
// relay_fifo_mem: simple dual-port word store, synchronous write, registered read-first read
module relay_fifo_mem #(
    parameter int W  = 30,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [W-1:0]  wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [W-1:0]  rd_data
);
    logic [W-1:0] mem [2**AW];
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        if (rd_en) rd_data <= mem[rd_addr];
    end
endmodule

// File: rtl/tmds_relay_buffer.sv
// tmds_relay_buffer: elastic TMDS word FIFO feeding a serializer; define TMDS_RELAY_STATS_EN for event counters
module tmds_relay_buffer
    import tmds_pkg::*;
#(
    parameter int NCH = 3,
    parameter int DEPTH_LOG2 = 4,
    parameter int START_FILL = 8,
    parameter int CLK_LANE = 1,
    parameter logic [NCH+CLK_LANE-1:0] TX_INV = '0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_vld,
    input  logic [NCH*10-1:0]            in_data,
    input  logic                         out_en,
    input  logic [1:0]                   mode,
    output logic [(NCH+CLK_LANE)*10-1:0] out_data,
    output logic                         running,
    output logic [DEPTH_LOG2:0]          level
`ifdef TMDS_RELAY_STATS_EN
    ,
    output logic [15:0]                  ovf_cnt,
    output logic [15:0]                  unf_cnt,
    output logic [15:0]                  resync_cnt
`endif
);
    localparam int DW = NCH * 10;
    localparam int OW = (NCH + CLK_LANE) * 10;
    localparam int AW = DEPTH_LOG2;
    localparam logic [AW:0] DEPTH = (AW+1)'(2 ** AW);
    localparam logic [AW:0] FILL_LVL = (AW+1)'(START_FILL);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);
    localparam logic [DW-1:0] BLANK_WORD = {NCH{BLANK_TOKEN}};

    state_e state, state_nx;
    mode_e mode_q;
    logic [AW:0] wptr, rptr;
    logic empty, full, rd, wr, unf, rd_q, en_q;
    logic [DW-1:0] head, frz, data_sel;
    logic [OW-1:0] raw, rst_raw, inv_mask;

    assign level = wptr - rptr;
    assign running = state == ST_RUN;

    always_comb begin
        empty = level == '0;
        full = level == DEPTH;
        rd = state == ST_RUN && out_en && !empty;
        wr = in_vld && (!full || rd);
        unf = out_en && empty;
        state_nx = state;
        if (state == ST_RUN && unf) state_nx = ST_FILL;
        else if (state == ST_FILL && level >= FILL_LVL) state_nx = ST_RUN;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_FILL;
        else state <= state_nx;
    end

    // Full-and-read writes the slot being read; read-first keeps the old head
    relay_fifo_mem #(.W(DW), .AW(AW)) u_mem (
        .clk(clk),
        .wr_en(wr),
        .wr_addr(wptr[AW-1:0]),
        .wr_data(in_data),
        .rd_en(rd),
        .rd_addr(rptr[AW-1:0]),
        .rd_data(head)
    );

    always_comb begin
        data_sel = mode_q == MODE_FREEZE ? frz : (mode_q == MODE_PASS && rd_q ? head : BLANK_WORD);
    end

    if (CLK_LANE != 0) begin : g_clk
        assign raw = {CLK_PATTERN, data_sel};
        assign rst_raw = {CLK_PATTERN, BLANK_WORD};
    end else begin : g_noclk
        assign raw = data_sel;
        assign rst_raw = BLANK_WORD;
    end

    for (genvar k = 0; k < NCH + CLK_LANE; k++) begin : g_inv
        assign inv_mask[10*k +: 10] = {10{TX_INV[k]}};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
            rd_q <= 1'b0;
            en_q <= 1'b0;
            mode_q <= MODE_PASS;
            frz <= BLANK_WORD;
            out_data <= rst_raw ^ inv_mask;
        end else begin
            if (wr) wptr <= wptr + PTR_ONE;
            if (rd) rptr <= rptr + PTR_ONE;
            rd_q <= rd;
            en_q <= out_en;
            mode_q <= mode_e'(mode);
            if (rd_q && mode_q == MODE_PASS) frz <= head;
            if (en_q) out_data <= raw ^ inv_mask;
        end
    end

`ifdef TMDS_RELAY_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_cnt <= '0;
            unf_cnt <= '0;
            resync_cnt <= '0;
        end else begin
            if (in_vld && !wr && ovf_cnt != 16'hFFFF) ovf_cnt <= ovf_cnt + 16'd1;
            if (unf && unf_cnt != 16'hFFFF) unf_cnt <= unf_cnt + 16'd1;
            if (state == ST_RUN && unf && resync_cnt != 16'hFFFF) resync_cnt <= resync_cnt + 16'd1;
        end
    end
`endif
endmodule

// File: doc/tmds_relay_buffer.md
TMDS_RELAY_BUFFER -- requirements
Module: tmds_relay_buffer

Interface
REQ-001 Parameter NCH, default 3: number of TMDS data channels.
REQ-002 Parameter DEPTH_LOG2, default 4: FIFO depth is 2**DEPTH_LOG2 entries of NCH*10 bits.
REQ-003 Parameter START_FILL, default 8: occupancy needed to leave FILL; legal range 1..2**DEPTH_LOG2.
REQ-004 Parameter CLK_LANE, default 1: when 1, the output carries an extra clock lane of 10'b0000011111 above the data lanes.
REQ-005 Parameter TX_INV, default all zeros, width NCH+CLK_LANE: per-lane output inversion mask.
REQ-006 clk  input  1  sole clock; all logic on its rising edge.
REQ-007 rst_n  input  1  reset, synchronous, active-low.
REQ-008 in_vld  input  1  in_data holds a bonded word this cycle; the source cannot be stalled.
REQ-009 in_data  input  NCH*10  bonded 10-bit TMDS words, channel i at [10i +: 10].
REQ-010 out_en  input  1  serializer consumes one word this cycle.
REQ-011 mode  input  2  00 pass, 01 blank, 10 freeze, 11 reserved (treated as 01).
REQ-012 out_data  output  (NCH+CLK_LANE)*10  registered output word, with TX_INV applied.
REQ-013 running  output  1  high in state RUN.
REQ-014 level  output  DEPTH_LOG2+1  current FIFO occupancy.

Function
REQ-015 FIFO write: occurs when in_vld=1 and either level < depth, or level = depth and a read occurs in the same cycle.
REQ-016 Overflow event: in_vld=1 with the write rejected; the word is dropped and the pointers are unchanged.
REQ-017 State machine: FILL to RUN when level >= START_FILL. RUN to FILL on an underflow event (out_en=1 with level=0). No other transitions.
REQ-018 FIFO read: occurs only in RUN, with out_en=1 and level>0.
REQ-019 No bypass path: a write into an empty FIFO is not readable in the same cycle, so that cycle is an underflow.
REQ-020 out_data updates only on cycles with out_en=1, one cycle after the read decision. It holds its value otherwise.
REQ-021 Pass mode, word with a read: out_data = FIFO head.
REQ-022 Pass mode, word without a read: every data lane = BLANK_TOKEN (10'b1101010100).
REQ-023 Blank mode: reads proceed normally, but every data lane outputs BLANK_TOKEN.
REQ-024 Freeze mode: reads proceed normally, but out_data data lanes repeat the last word actually read in pass mode.
REQ-025 Clock lane: constant 10'b0000011111 before inversion; it is never subject to mode.
REQ-026 Inversion: lane k bits are XORed with TX_INV[k] as the final step before the out_data register.
REQ-027 level is the exact count; it wraps never. Pointers are DEPTH_LOG2+1 bits wide and use the wrap bit for the full/empty distinction.
REQ-028 A mode change takes effect on the next out_en word; no flush.

Reset
REQ-029 While rst_n=0 at a clock edge: pointers=0, level=0, state=FILL, running=0, freeze register = BLANK_TOKEN.
REQ-030 Also under reset, out_data = BLANK_TOKEN on data lanes and the clock pattern on the clock lane, both inverted per TX_INV.
REQ-031 Reset asserted mid-stream discards FIFO contents; the first post-reset write lands at address 0.

Configuration
REQ-032 Macro TMDS_RELAY_STATS_EN defined: add outputs ovf_cnt[15:0], unf_cnt[15:0] and resync_cnt[15:0].
REQ-033 Each counter is saturating at 16'hFFFF, counts overflow events, underflow events and RUN-to-FILL transitions respectively, and is cleared by reset.
REQ-034 Macro absent: these ports and their logic do not exist; all other behaviour is identical.

Structure
REQ-035 Package tmds_pkg holds BLANK_TOKEN, the CLK_PATTERN constant, the mode encoding enum and the state enum.
REQ-036 Storage is a sub-module relay_fifo_mem: simple dual-port, synchronous write, registered read, inferable as distributed RAM.
REQ-037 Pointers, state machine, mode mux and inversion live in the top module.

Verification
REQ-038 Reset, 20 in_vld words with out_en=1 -> out_data stays BLANK; running rises the cycle after level reaches 8; the first pass word equals input word #0.
REQ-039 Continuous in_vld and out_en for 1000 cycles, mode=00 -> output sequence equals input sequence delayed; zero overflow and underflow.
REQ-040 in_vld held and out_en=0 for 20 cycles -> level saturates at 16; ovf_cnt=4; the next 16 outputs are words #0..#15.
REQ-041 Stop in_vld while RUN -> after the FIFO drains, one underflow occurs; running=0 on the next cycle; resync_cnt=1; BLANK is output until level reaches 8 again.
REQ-042 Mode sequence 00 -> 10 -> 01 -> 00 during streaming -> the freeze output repeats the last pass word; the blank output is all BLANK_TOKEN; the clock lane is always 0000011111.
REQ-043 TX_INV=4'b1100, rst_n pulsed low mid-stream -> out_data equals the inverted BLANK/clock pattern; level=0; state returns to FILL.
